branch_predictor_tournament: RTL and testbench
==============================================

Name: branch_predictor_tournament

Overview:
- Tournament direction predictor feeding the decode stage's branch interface.
- Supplies, in the decode cycle:
  - final prediction
  - the gshare and 2-bit component predictions
  - the global history snapshot.
- These travel down the pipeline with the branch. The EX-stage branch result feeds back to train the tables and repair the speculative global history.
- Sits beside decode, upstream of the decode glue; consumes what the EX glue emits.

Parameters:
- ADDR_WIDTH, 16, PC width in bits (matches core ADDR_WIDTH).
- INDEX_BITS, 8, log2 of entries in each table; tables are flop arrays.
- HISTORY_BITS, 8, global history length; must be ≤ INDEX_BITS.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- i_req_valid  in  1  decode holds a conditional branch (is_branch_jump & ~is_jump).
- i_req_stall  in  1  decode stalled this cycle; request must not commit.
- i_req_pc  in  ADDR_WIDTH  PC of decode-stage branch.
- o_prediction  out  1  final prediction, 1 = taken.
- o_prediction_gshare  out  1  gshare component prediction.
- o_prediction_2bit  out  1  bimodal component prediction.
- o_ghistory  out  HISTORY_BITS  GHR value used for this prediction.
- i_res_valid  in  1  EX branch result valid.
- i_res_pc  in  ADDR_WIDTH  PC of resolved branch.
- i_res_outcome  in  1  actual direction.
- i_res_prediction  in  1  final prediction carried with the branch.
- i_res_prediction_gshare  in  1  carried gshare prediction.
- i_res_prediction_2bit  in  1  carried bimodal prediction.
- i_res_ghistory  in  HISTORY_BITS  carried GHR snapshot.
- o_mispredict  out  1  registered; high one cycle after a resolved mispredict.

Behaviour:
- Indexing:
  - bimodal/chooser index = pc[INDEX_BITS+1:2]
  - gshare index = pc[INDEX_BITS+1:2] XOR zero-extended GHR
  - the same formulas apply at resolve time using i_res_pc and i_res_ghistory.
- Counters: 2-bit saturating; predict taken when MSB = 1. Increment on taken and saturate at 3; decrement on not-taken and saturate at 0.
- Prediction path is combinational from i_req_pc and current state (0-cycle latency). o_ghistory = current GHR. Outputs are driven regardless of i_req_valid.
- o_prediction = chooser MSB ? gshare : bimodal.
- Fire = i_req_valid & ~i_req_stall & ~i_res_mispredicting. Only a fire shifts the GHR: GHR <= {GHR[HISTORY_BITS-2:0], o_prediction}. A stalled request re-presents with an unchanged GHR and is never double-shifted.
- Resolve, on i_res_valid, all written at the clock edge:
  - bimodal[idx] and gshare[gidx] are trained toward i_res_outcome.
  - chooser[idx] is trained only when i_res_prediction_gshare ≠ i_res_prediction_2bit: increment if gshare was correct, decrement otherwise.
- Mispredict (i_res_valid & i_res_prediction ≠ i_res_outcome):
  - GHR <= {i_res_ghistory[HISTORY_BITS-2:0], i_res_outcome}.
  - Overrides any same-cycle fire; that decode branch is flushed by the hazard controller.
  - o_mispredict <= 1 for exactly one cycle.
- Same-cycle read/write to the same entry: the prediction returns the pre-update value; the update is visible next cycle.
- Reset, including mid-operation, completes in one edge:
  - bimodal and gshare entries = 2'b01 (weakly not-taken)
  - chooser entries = 2'b10 (weakly prefer gshare)
  - GHR = 0, o_mispredict = 0
  - any i_res_valid in the reset cycle is ignored.
- Combinational outputs after reset: o_prediction = 0, o_prediction_gshare = 0, o_prediction_2bit = 0, o_ghistory = 0.

Optional Feature:
- Macro: BP_TOURNAMENT_EN.
- Defined: chooser table present; behaviour as above.
- Undefined:
  - no chooser storage; o_prediction = gshare prediction.
  - bimodal is still trained and o_prediction_2bit is still driven, so downstream ports are unchanged.

Test Plan:
- Reset, then pc=0x0040, i_req_valid=1, no stall → o_prediction=0, o_prediction_2bit=0, o_prediction_gshare=0, o_ghistory=0; next cycle GHR=0x00 (shifted-in 0).
- Resolve pc=0x0040 taken twice, ghistory=0, predictions all 0 → first resolve asserts o_mispredict next cycle and sets GHR=0x01. Bimodal[0x10] 01→10→11; request pc=0x0040 then yields o_prediction_2bit=1.
- Stall test: i_req_valid=1, i_req_stall=1 for 3 cycles with prediction 1 → GHR unchanged; on release, GHR shifts exactly once.
- Simultaneous fire and mispredict: GHR=0xA5, request fires predicting 1; same cycle resolve with ghistory=0x3C, outcome=1, prediction=0 → GHR=0x79, o_mispredict=1 next cycle.
- Chooser: gshare correct, bimodal wrong on idx 0x10 → chooser 10→11. Both wrong → chooser unchanged. Without BP_TOURNAMENT_EN, o_prediction always equals o_prediction_gshare.
- Reset asserted mid-stream after training → all outputs and GHR return to reset values next cycle; a resolve presented during reset leaves tables at 01/01/10.

Source files
------------

// File: rtl/branch_predictor_tournament_if.sv
// Decode-request / EX-resolve bundle between the pipeline and the tournament predictor.
interface branch_predictor_tournament_if #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned HISTORY_BITS = 8
);
  logic                    i_req_valid;
  logic                    i_req_stall;
  logic [ADDR_WIDTH-1:0]   i_req_pc;
  logic                    o_prediction;
  logic                    o_prediction_gshare;
  logic                    o_prediction_2bit;
  logic [HISTORY_BITS-1:0] o_ghistory;
  logic                    i_res_valid;
  logic [ADDR_WIDTH-1:0]   i_res_pc;
  logic                    i_res_outcome;
  logic                    i_res_prediction;
  logic                    i_res_prediction_gshare;
  logic                    i_res_prediction_2bit;
  logic [HISTORY_BITS-1:0] i_res_ghistory;
  logic                    o_mispredict;

  modport master (
    output i_req_valid, i_req_stall, i_req_pc,
    output i_res_valid, i_res_pc, i_res_outcome, i_res_prediction,
    output i_res_prediction_gshare, i_res_prediction_2bit, i_res_ghistory,
    input  o_prediction, o_prediction_gshare, o_prediction_2bit, o_ghistory, o_mispredict
  );

  modport slave (
    input  i_req_valid, i_req_stall, i_req_pc,
    input  i_res_valid, i_res_pc, i_res_outcome, i_res_prediction,
    input  i_res_prediction_gshare, i_res_prediction_2bit, i_res_ghistory,
    output o_prediction, o_prediction_gshare, o_prediction_2bit, o_ghistory, o_mispredict
  );
endinterface

// File: rtl/branch_predictor_tournament.sv
// Tournament (gshare + bimodal) branch direction predictor with speculative GHR repair.
// Define BP_TOURNAMENT_EN to include the chooser table; otherwise gshare alone decides.
module branch_predictor_tournament #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned INDEX_BITS   = 8,
  parameter int unsigned HISTORY_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  branch_predictor_tournament_if.slave bp
);
  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam logic [1:0]  CNT_WEAK_NT = 2'b01;
  localparam logic [1:0]  CNT_WEAK_T  = 2'b10;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  logic [1:0]              bim_q [ENTRIES];
  logic [1:0]              bim_d [ENTRIES];
  logic [1:0]              gsh_q [ENTRIES];
  logic [1:0]              gsh_d [ENTRIES];
`ifdef BP_TOURNAMENT_EN
  logic [1:0]              cho_q [ENTRIES];
  logic [1:0]              cho_d [ENTRIES];
`endif
  logic [HISTORY_BITS-1:0] ghr_q, ghr_d;
  logic                    mispredict_q, mispredict_d;

  logic [INDEX_BITS-1:0]   req_idx, req_gidx, res_idx, res_gidx;
  logic                    pred_gshare, pred_2bit, pred_final;
  logic                    res_mispredict, fire;

  assign req_idx  = bp.i_req_pc[INDEX_BITS+1:2];
  assign req_gidx = req_idx ^ INDEX_BITS'(ghr_q);
  assign res_idx  = bp.i_res_pc[INDEX_BITS+1:2];
  assign res_gidx = res_idx ^ INDEX_BITS'(bp.i_res_ghistory);

  assign pred_gshare = gsh_q[req_gidx][1];
  assign pred_2bit   = bim_q[req_idx][1];
`ifdef BP_TOURNAMENT_EN
  assign pred_final  = cho_q[req_idx][1] ? pred_gshare : pred_2bit;
`else
  assign pred_final  = pred_gshare;
`endif

  assign res_mispredict = bp.i_res_valid & (bp.i_res_prediction != bp.i_res_outcome);
  assign fire           = bp.i_req_valid & ~bp.i_req_stall & ~res_mispredict;

  assign bp.o_prediction        = pred_final;
  assign bp.o_prediction_gshare = pred_gshare;
  assign bp.o_prediction_2bit   = pred_2bit;
  assign bp.o_ghistory          = ghr_q;
  assign bp.o_mispredict        = mispredict_q;

  // Table training and GHR update; a resolve-side repair beats a same-cycle fire.
  always_comb begin
    bim_d        = bim_q;
    gsh_d        = gsh_q;
`ifdef BP_TOURNAMENT_EN
    cho_d        = cho_q;
`endif
    ghr_d        = ghr_q;
    mispredict_d = res_mispredict;

    if (bp.i_res_valid) begin
      bim_d[res_idx]  = sat_step(bim_q[res_idx], bp.i_res_outcome);
      gsh_d[res_gidx] = sat_step(gsh_q[res_gidx], bp.i_res_outcome);
`ifdef BP_TOURNAMENT_EN
      if (bp.i_res_prediction_gshare != bp.i_res_prediction_2bit)
        cho_d[res_idx] = sat_step(cho_q[res_idx],
                                  bp.i_res_prediction_gshare == bp.i_res_outcome);
`endif
    end

    if (res_mispredict)
      ghr_d = {bp.i_res_ghistory[HISTORY_BITS-2:0], bp.i_res_outcome};
    else if (fire)
      ghr_d = {ghr_q[HISTORY_BITS-2:0], pred_final};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        bim_q[i] <= CNT_WEAK_NT;
        gsh_q[i] <= CNT_WEAK_NT;
`ifdef BP_TOURNAMENT_EN
        cho_q[i] <= CNT_WEAK_T;
`endif
      end
      ghr_q        <= '0;
      mispredict_q <= 1'b0;
    end else begin
      bim_q        <= bim_d;
      gsh_q        <= gsh_d;
`ifdef BP_TOURNAMENT_EN
      cho_q        <= cho_d;
`endif
      ghr_q        <= ghr_d;
      mispredict_q <= mispredict_d;
    end
  end

  // PC bits outside the index window (and carried component bits without a chooser) are not needed.
  logic unused_bits;
`ifdef BP_TOURNAMENT_EN
  assign unused_bits = ^{bp.i_req_pc[1:0], bp.i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2],
                         bp.i_res_pc[1:0], bp.i_res_pc[ADDR_WIDTH-1:INDEX_BITS+2]};
`else
  assign unused_bits = ^{bp.i_req_pc[1:0], bp.i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2],
                         bp.i_res_pc[1:0], bp.i_res_pc[ADDR_WIDTH-1:INDEX_BITS+2],
                         bp.i_res_prediction_gshare, bp.i_res_prediction_2bit,
                         CNT_WEAK_T};
`endif
endmodule

// File: tb/tb_branch_predictor_tournament.sv
// Directed bench for branch_predictor_tournament with an array-based reference model.
module tb_branch_predictor_tournament;
  localparam int unsigned AW = 16;
  localparam int unsigned IB = 8;
  localparam int unsigned HB = 8;
  localparam int NENT = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_tournament_if #(.ADDR_WIDTH(AW), .HISTORY_BITS(HB)) bif ();

  branch_predictor_tournament #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .HISTORY_BITS(HB)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bif)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer counters and history.
  int  m_bim [NENT];
  int  m_gsh [NENT];
  int  m_cho [NENT];
  int  m_ghr;
  bit  m_mis;
  bit  model_ok = 1'b0;

  function automatic int idx_of(input logic [AW-1:0] pc);
    return (int'(pc) >> 2) % NENT;
  endfunction

  function automatic int train(input int c, input bit up);
    if (up) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic bit model_gshare(input logic [AW-1:0] pc);
    return m_gsh[idx_of(pc) ^ m_ghr] >= 2;
  endfunction

  function automatic bit model_2bit(input logic [AW-1:0] pc);
    return m_bim[idx_of(pc)] >= 2;
  endfunction

  function automatic bit model_pred(input logic [AW-1:0] pc);
`ifdef BP_TOURNAMENT_EN
    return (m_cho[idx_of(pc)] >= 2) ? model_gshare(pc) : model_2bit(pc);
`else
    return model_gshare(pc);
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        m_bim[i] = 1; m_gsh[i] = 1; m_cho[i] = 2;
      end
      m_ghr = 0; m_mis = 1'b0; model_ok = 1'b1;
    end else if (model_ok) begin
      bit ep, mp, fire;
      int ri, rg;
      ep   = model_pred(bif.i_req_pc);
      mp   = bif.i_res_valid && (bif.i_res_prediction != bif.i_res_outcome);
      fire = bif.i_req_valid && !bif.i_req_stall && !mp;
      if (bif.i_res_valid) begin
        ri = idx_of(bif.i_res_pc);
        rg = ri ^ int'(bif.i_res_ghistory);
        m_bim[ri] = train(m_bim[ri], bif.i_res_outcome);
        m_gsh[rg] = train(m_gsh[rg], bif.i_res_outcome);
        if (bif.i_res_prediction_gshare != bif.i_res_prediction_2bit)
          m_cho[ri] = train(m_cho[ri], bif.i_res_prediction_gshare == bif.i_res_outcome);
      end
      if (mp)        m_ghr = ((int'(bif.i_res_ghistory) << 1) | int'(bif.i_res_outcome)) % 256;
      else if (fire) m_ghr = ((m_ghr << 1) | int'(ep)) % 256;
      m_mis = mp;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("cmp_pred",   32'(bif.o_prediction),        32'(model_pred(bif.i_req_pc)));
      check("cmp_gshare", 32'(bif.o_prediction_gshare), 32'(model_gshare(bif.i_req_pc)));
      check("cmp_2bit",   32'(bif.o_prediction_2bit),   32'(model_2bit(bif.i_req_pc)));
      check("cmp_ghist",  32'(bif.o_ghistory),          32'(m_ghr));
      check("cmp_mispr",  32'(bif.o_mispredict),        32'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic [AW-1:0] pc, input bit outcome, input bit pred,
                         input bit pg, input bit pb, input logic [HB-1:0] gh);
    bif.i_res_valid = 1'b1;  bif.i_res_pc = pc;  bif.i_res_outcome = outcome;
    bif.i_res_prediction = pred;  bif.i_res_prediction_gshare = pg;
    bif.i_res_prediction_2bit = pb;  bif.i_res_ghistory = gh;
  endtask

  task automatic set_req(input bit valid, input bit stall, input logic [AW-1:0] pc);
    bif.i_req_valid = valid;  bif.i_req_stall = stall;  bif.i_req_pc = pc;
  endtask

  initial begin
    set_req(1'b0, 1'b0, '0);
    set_res('0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    bif.i_res_valid = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_pred",   32'(bif.o_prediction),        32'h0);
    check("rst_gshare", 32'(bif.o_prediction_gshare), 32'h0);
    check("rst_2bit",   32'(bif.o_prediction_2bit),   32'h0);
    check("rst_ghist",  32'(bif.o_ghistory),          32'h0);
    check("rst_mispr",  32'(bif.o_mispredict),        32'h0);

    // First request fires with a not-taken prediction.
    set_req(1'b1, 1'b0, 16'h0040);
    #1 check("t1_pred", 32'(bif.o_prediction), 32'h0);
    step();
    set_req(1'b0, 1'b0, 16'h0040);
    #1 check("t1_ghist", 32'(bif.o_ghistory), 32'h00);

    // Two taken resolves at pc 0x40, both mispredicted.
    set_res(16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("t2_mispr1", 32'(bif.o_mispredict), 32'h1);
    check("t2_ghist1", 32'(bif.o_ghistory),   32'h01);
    step();
    bif.i_res_valid = 1'b0;
    check("t2_mispr2", 32'(bif.o_mispredict), 32'h1);
    step();
    check("t2_mispr_clr", 32'(bif.o_mispredict), 32'h0);
    #1;
    check("t2_2bit",   32'(bif.o_prediction_2bit),   32'h1);
    check("t2_gshare", 32'(bif.o_prediction_gshare), 32'h0);
    check("t2_pred",   32'(bif.o_prediction),        32'h0);
    check("t2_ghist",  32'(bif.o_ghistory),          32'h01);

    // Stalled taken prediction must not shift history until released.
    set_req(1'b1, 1'b1, 16'h0044);
    #1 check("st_pred", 32'(bif.o_prediction), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_hold", 32'(bif.o_ghistory), 32'h01);
    end
    bif.i_req_stall = 1'b0;
    step();
    bif.i_req_valid = 1'b0;
    check("st_shift", 32'(bif.o_ghistory), 32'h03);
    step();
    check("st_once", 32'(bif.o_ghistory), 32'h03);

    // Force GHR to 0xA5, then collide a fire with a mispredict repair.
    set_res(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 8'h52);
    step();
    check("sim_setup", 32'(bif.o_ghistory), 32'hA5);
    set_req(1'b1, 1'b0, 16'h0200);
    set_res(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    step();
    set_req(1'b0, 1'b0, 16'h0200);
    bif.i_res_valid = 1'b0;
    check("sim_ghist", 32'(bif.o_ghistory),   32'h79);
    check("sim_mispr", 32'(bif.o_mispredict), 32'h1);

    // Zero the GHR through a not-taken repair at an unrelated entry.
    set_res(16'h03FC, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    step();
    check("zero_ghist", 32'(bif.o_ghistory), 32'h00);

    // Chooser at idx 0x20: inc (gshare right), hold (both wrong), dec (bimodal right).
    set_res(16'h0080, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01);
    step();
    set_res(16'h0080, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
    step();
    set_res(16'h0080, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01);
    step();
    bif.i_res_valid = 1'b0;
    set_req(1'b0, 1'b0, 16'h0080);
    #1;
    check("ch_ghist",  32'(bif.o_ghistory),          32'h00);
    check("ch_2bit",   32'(bif.o_prediction_2bit),   32'h1);
    check("ch_gshare", 32'(bif.o_prediction_gshare), 32'h0);
    check("ch_pred",   32'(bif.o_prediction),        32'h0);
    check("ch_mispr",  32'(bif.o_mispredict),        32'h0);

    // Mid-stream reset with a mispredicting resolve that must be ignored.
    step();
    rst = 1'b1;
    set_res(16'h0080, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01);
    step();
    rst = 1'b0;
    bif.i_res_valid = 1'b0;
    #1;
    check("mrst_ghist",  32'(bif.o_ghistory),          32'h00);
    check("mrst_mispr",  32'(bif.o_mispredict),        32'h0);
    check("mrst_2bit",   32'(bif.o_prediction_2bit),   32'h0);
    check("mrst_gshare", 32'(bif.o_prediction_gshare), 32'h0);
    check("mrst_pred",   32'(bif.o_prediction),        32'h0);
    set_req(1'b0, 1'b0, 16'h0040);
    #1 check("mrst_2bit_40", 32'(bif.o_prediction_2bit), 32'h0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
